// File: rtl/bike_crash_monitor.sv
// Frame-level crash confirmation, life counting and respawn hold-off for the bike game.
// All outputs registered; crash/respawn pulse one cycle after the deciding frame_end.
module bike_crash_monitor #(
  parameter int FRAME_PIXELS   = 307200,
  parameter int CONFIRM_FRAMES = 2,
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_master_switch,
  input  logic [18:0] i_addr,
  input  logic        i_edge_detected,
  output logic        o_crash,
  output logic        o_respawn,
  output logic        o_freeze_bike,
  output logic [1:0]  o_lives_left,
  output logic        o_game_over,
  output logic [1:0]  o_state
);

  localparam logic [18:0] LP_LAST    = 19'(FRAME_PIXELS - 1);
  localparam logic [2:0]  LP_CONFIRM = 3'(CONFIRM_FRAMES);
  localparam logic [1:0]  LP_LIVES   = 2'(LIVES);
  localparam logic [7:0]  LP_HOLD    = 8'(RESPAWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CRASHED = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] r_lives;
  logic       r_hit_flag;
  logic [2:0] r_hit_cnt;
  logic [7:0] r_hold_cnt;
  logic       r_crash;
  logic       r_respawn;
  logic       r_freeze;
  logic       r_game_over;

  logic       w_frame_end;
  logic       w_frame_hit;
  logic [2:0] w_hit_inc;
  logic       w_confirm;
  logic [1:0] w_lives_dec;

  always_comb begin
    w_frame_end = (i_addr == LP_LAST);
    // A hit on the very last pixel still belongs to the frame being closed.
    w_frame_hit = r_hit_flag | i_edge_detected;
    w_hit_inc   = (r_hit_cnt >= LP_CONFIRM) ? LP_CONFIRM : r_hit_cnt + 3'd1;
    w_confirm   = w_frame_hit && (w_hit_inc == LP_CONFIRM);
    w_lives_dec = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_lives     <= LP_LIVES;
      r_hit_flag  <= 1'b0;
      r_hit_cnt   <= 3'd0;
      r_hold_cnt  <= 8'd0;
      r_crash     <= 1'b0;
      r_respawn   <= 1'b0;
      r_freeze    <= 1'b1;
      r_game_over <= 1'b0;
    end else begin
      r_crash   <= 1'b0;
      r_respawn <= 1'b0;

      if (w_frame_end)
        r_hit_flag <= 1'b0;
      else if (r_state == S_RUN && i_edge_detected)
        r_hit_flag <= 1'b1;

      if (!i_master_switch) begin
        // Switch-off wins over any crash or respawn decided this cycle.
        r_state     <= S_IDLE;
        r_lives     <= LP_LIVES;
        r_hit_cnt   <= 3'd0;
        r_hold_cnt  <= 8'd0;
        r_freeze    <= 1'b1;
        r_game_over <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_RUN;
            r_lives     <= LP_LIVES;
            r_hit_cnt   <= 3'd0;
            r_freeze    <= 1'b0;
            r_game_over <= 1'b0;
          end

          S_RUN: begin
            if (w_frame_end) begin
              if (w_confirm) begin
                r_crash   <= 1'b1;
                r_lives   <= w_lives_dec;
                r_hit_cnt <= 3'd0;
                r_freeze  <= 1'b1;
                if (r_lives == 2'd1) begin
                  r_state     <= S_OVER;
                  r_game_over <= 1'b1;
                end else begin
                  r_state    <= S_CRASHED;
                  r_hold_cnt <= LP_HOLD;
                end
              end else if (w_frame_hit) begin
                r_hit_cnt <= w_hit_inc;
              end else begin
                r_hit_cnt <= 3'd0;
              end
            end
          end

          S_CRASHED: begin
            if (w_frame_end) begin
              if (r_hold_cnt == 8'd1) begin
                r_respawn  <= 1'b1;
                r_state    <= S_RUN;
                r_hold_cnt <= 8'd0;
                r_hit_cnt  <= 3'd0;
                r_freeze   <= 1'b0;
              end else begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
              end
            end
          end

          S_OVER: begin
            r_freeze    <= 1'b1;
            r_game_over <= 1'b1;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_crash       = r_crash;
  assign o_respawn     = r_respawn;
  assign o_freeze_bike = r_freeze;
  assign o_lives_left  = r_lives;
  assign o_game_over   = r_game_over;
  assign o_state       = r_state;

endmodule

// File: tb/tb_bike_crash_monitor.sv
// Directed bench for bike_crash_monitor; frame ends are produced by jumping addr to the last pixel.
module tb_bike_crash_monitor;

  localparam int LAST = 307199;

  logic        clock = 1'b0;
  logic        reset;
  logic        master_switch;
  logic [18:0] addr;
  logic        edge_detected;
  logic        crash;
  logic        respawn;
  logic        freeze_bike;
  logic [1:0]  lives_left;
  logic        game_over;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  bike_crash_monitor dut (
    .i_clock         (clock),
    .i_reset         (reset),
    .i_master_switch (master_switch),
    .i_addr          (addr),
    .i_edge_detected (edge_detected),
    .o_crash         (crash),
    .o_respawn       (respawn),
    .o_freeze_bike   (freeze_bike),
    .o_lives_left    (lives_left),
    .o_game_over     (game_over),
    .o_state         (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pixel(input int a, input logic e);
    addr = 19'(a);
    edge_detected = e;
    tick();
    edge_detected = 1'b0;
    addr = 19'd0;
  endtask

  task automatic frame_end(input logic e);
    pixel(LAST, e);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_lives"}, int'(lives_left), 3);
    chk({tag, "_freeze"}, int'(freeze_bike), 1);
    chk({tag, "_crash"}, int'(crash), 0);
    chk({tag, "_respawn"}, int'(respawn), 0);
    chk({tag, "_over"}, int'(game_over), 0);
  endtask

  // Runs n frame_ends in the hold-off, returns pulse count and the frame index of the last pulse.
  task automatic hold_frames(input int n, input logic e, output int pulses, output int at);
    pulses = 0;
    at = -1;
    for (int i = 1; i <= n; i++) begin
      pixel(2000, e);
      frame_end(e);
      if (respawn) begin
        pulses++;
        at = i;
      end
    end
  endtask

  int p, at;

  initial begin
    reset = 1'b1;
    master_switch = 1'b0;
    addr = 19'd0;
    edge_detected = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");

    reset = 1'b0;
    master_switch = 1'b1;
    tick();
    chk("start_state", int'(state), 1);
    chk("start_lives", int'(lives_left), 3);
    chk("start_freeze", int'(freeze_bike), 0);

    p = 0;
    for (int i = 0; i < 5; i++) begin
      pixel(100, 1'b0);
      frame_end(1'b0);
      p += int'(crash);
    end
    chk("quiet_crashes", p, 0);
    chk("quiet_state", int'(state), 1);

    // hit, miss, hit: the miss resets the consecutive count
    pixel(1000, 1'b1);
    frame_end(1'b0);
    chk("gap_f0_crash", int'(crash), 0);
    frame_end(1'b0);
    chk("gap_f1_crash", int'(crash), 0);
    pixel(1000, 1'b1);
    frame_end(1'b0);
    chk("gap_f2_crash", int'(crash), 0);
    chk("gap_lives", int'(lives_left), 3);
    frame_end(1'b0);

    pixel(1000, 1'b1);
    frame_end(1'b0);
    chk("c1_first_crash", int'(crash), 0);
    pixel(5000, 1'b1);
    frame_end(1'b0);
    chk("c1_crash", int'(crash), 1);
    chk("c1_lives", int'(lives_left), 2);
    chk("c1_state", int'(state), 2);
    chk("c1_freeze", int'(freeze_bike), 1);
    tick();
    chk("c1_pulse_width", int'(crash), 0);
    hold_frames(60, 1'b0, p, at);
    chk("c1_resp_pulses", p, 1);
    chk("c1_resp_at", at, 60);
    chk("c1_resp_state", int'(state), 1);
    chk("c1_resp_freeze", int'(freeze_bike), 0);
    tick();
    chk("c1_resp_width", int'(respawn), 0);

    // last-pixel hits only
    frame_end(1'b1);
    chk("c2_first_crash", int'(crash), 0);
    frame_end(1'b1);
    chk("c2_crash", int'(crash), 1);
    chk("c2_respawn_excl", int'(respawn), 0);
    chk("c2_lives", int'(lives_left), 1);
    chk("c2_state", int'(state), 2);
    // edges during hold-off must be ignored
    hold_frames(60, 1'b1, p, at);
    chk("c2_resp_pulses", p, 1);
    chk("c2_resp_at", at, 60);

    frame_end(1'b1);
    chk("c3_first_crash", int'(crash), 0);
    pixel(1234, 1'b1);
    frame_end(1'b0);
    chk("c3_crash", int'(crash), 1);
    chk("c3_lives", int'(lives_left), 0);
    chk("c3_state", int'(state), 3);
    chk("c3_over", int'(game_over), 1);
    chk("c3_freeze", int'(freeze_bike), 1);
    hold_frames(70, 1'b1, p, at);
    chk("over_no_respawn", p, 0);
    chk("over_state", int'(state), 3);
    chk("over_lives", int'(lives_left), 0);

    master_switch = 1'b0;
    tick();
    check_idle_outputs("off");
    master_switch = 1'b1;
    tick();
    chk("restart_state", int'(state), 1);
    chk("restart_lives", int'(lives_left), 3);
    chk("restart_over", int'(game_over), 0);

    // switch dropped on the confirming frame_end
    frame_end(1'b1);
    addr = 19'(LAST);
    edge_detected = 1'b1;
    master_switch = 1'b0;
    tick();
    edge_detected = 1'b0;
    addr = 19'd0;
    check_idle_outputs("drop");
    tick();
    chk("drop_late_crash", int'(crash), 0);

    master_switch = 1'b1;
    tick();
    frame_end(1'b1);
    frame_end(1'b1);
    chk("mid_crash_state", int'(state), 2);
    pixel(50, 1'b0);
    frame_end(1'b0);
    reset = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
